vadd_result_pack: RTL and testbench
===================================

// Module: vadd_result_pack
// PURPOSE
//  Output stage directly downstream of the vector add/sub block. Takes its 81-bit raw guard-bit
//  result and strips the per-byte guard bits to recover the 64-bit element data. Extracts
//  per-element carry/borrow flags and packs them into 64-bit mask words for mask-producing ops
//  (vmadc/vmsbc). Registers everything behind a valid/ready handshake toward vALU writeback.
// PARAMETERS
//  REQ_DATA_WIDTH   64  data lanes per beat; fixed at 64 (8 bytes)
//  RAW_WIDTH        81  raw adder result width (REQ_DATA_WIDTH+17)
//  SEW_WIDTH        2   element width code: 0=8b, 1=16b, 2=32b, 3=64b
//  OPSEL_WIDTH      5   opSel field, same encoding as the adder stage
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  in_valid   in   1    raw result beat valid
//  in_ready   out  1    stage can accept a beat this cycle
//  in_raw     in   81   raw adder result; byte i in bits [10i+9:10i]
//  in_sew     in   2    element width of this beat
//  in_opsel   in   5    opSel of this beat
//  in_mask_op in   1    1 = emit carry mask (vmadc/vmsbc), 0 = emit data
//  in_last    in   1    last beat of the instruction
//  out_valid  out  1    output word valid
//  out_ready  in   1    consumer accepts output word
//  out_data   out  64   packed data word, or mask word when out_is_mask=1
//  out_is_mask out 1    out_data holds a mask word
//  out_last   out  1    final output word of the instruction
// BEHAVIOUR
//  Reset (rst=0, async): out_valid=0, out_data=0, out_is_mask=0, out_last=0, mask_ptr=0, mask_acc=0.
//  Data extraction:
//   - out byte i = in_raw[10i+8:10i+1]. Bits 10i, 10i+9 and bit 80 are guard bits and are discarded.
//  Carry flags:
//   - One flag per element; n = 8>>sew elements per beat.
//   - Element k has top byte t = k*(1<<sew)+(1<<sew)-1.
//   - flag = in_opsel[4] ? in_raw[10t+9] : ~in_raw[10t+9].
//  Handshake:
//   - A beat is accepted when in_valid & in_ready.
//   - in_ready = ~out_valid | out_ready.
//   - Output is held stable while out_valid & ~out_ready.
//  Data ops (in_mask_op=0):
//   - Latency 1: the accepted beat appears registered on the next cycle with out_is_mask=0 and
//     out_last=in_last.
//  Mask ops (in_mask_op=1):
//   - Write the n flags into mask_acc[mask_ptr +: n]; then mask_ptr += n.
//   - Emit only when mask_ptr+n == 64 or in_last=1: out_data = updated mask_acc, with bits above
//     mask_ptr+n zeroed. Set out_is_mask=1, out_last=in_last. Clear mask_acc and mask_ptr to 0.
//   - A non-emitting mask beat is always accepted without asserting out_valid: in_ready=1 that
//     cycle even if out_valid is stalled; only mask_acc and mask_ptr update.
//  Counters and flags:
//   - mask_ptr is 7 bits and never exceeds 64. Wrap is exact because n divides 64.
//   - If sew changes mid-instruction, behaviour is undefined (not allowed upstream).
//   - Accept and output drain in the same cycle: the new word replaces the old one, with no
//     bubble (full throughput).
//   - Reset mid-instruction discards the partial mask and any pending output.
// TESTING
//  1 SEW=8 data add: in_raw from 0x01+0x02 per byte -> out_data=0x0303030303030303 next cycle.
//  2 SEW=8 vmadc, 8 beats of 0xFF+0x01 (all carry) -> one mask word 0xFFFFFFFFFFFFFFFF, out_last on 8th.
//  3 SEW=64 vmadc, 3 beats, carries 1,0,1, in_last on 3rd -> out_data=0x5, out_is_mask=1, out_last=1.
//  4 out_ready low 5 cycles with out_valid=1 -> out_data stable, in_ready=0; data beats stall, none lost.
//  5 rst pulsed low mid-mask (mask_ptr=24) -> all outputs 0 immediately; next instruction's mask starts at bit 0.
//  6 Back-to-back data beats with out_ready=1 -> one output per cycle, 100% throughput, order preserved.

Source files
------------

// File: rtl/vadd_result_pack.sv
// Output stage after the vector add/sub block: strips per-byte guard bits from the raw
// result, packs per-element carry/borrow flags into mask words, and registers toward writeback.
module vadd_result_pack #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int RAW_WIDTH      = 81,
    parameter int SEW_WIDTH      = 2,
    parameter int OPSEL_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [RAW_WIDTH-1:0]      in_raw,
    input  logic [SEW_WIDTH-1:0]      in_sew,
    input  logic [OPSEL_WIDTH-1:0]    in_opsel,
    input  logic                      in_mask_op,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REQ_DATA_WIDTH-1:0] out_data,
    output logic                      out_is_mask,
    output logic                      out_last
);

    localparam int NBYTES = REQ_DATA_WIDTH / 8;

    logic [REQ_DATA_WIDTH-1:0] w_data;
    logic [NBYTES-1:0]         w_ghi;
    logic [NBYTES-1:0]         w_glo;
    logic [NBYTES-1:0]         w_carry;
    logic [NBYTES-1:0]         w_lanes;
    logic [NBYTES-1:0]         w_flags;
    logic [3:0]                w_n;
    logic [6:0]                w_ptr_sum;
    logic                      w_emit;
    logic [REQ_DATA_WIDTH-1:0] w_acc_upd;
    logic [REQ_DATA_WIDTH-1:0] w_keep;
    logic                      w_out_free;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_unused;

    logic                      r_out_valid;
    logic [REQ_DATA_WIDTH-1:0] r_out_data;
    logic                      r_out_is_mask;
    logic                      r_out_last;
    logic [6:0]                r_mask_ptr;
    logic [REQ_DATA_WIDTH-1:0] r_mask_acc;

    // Byte i occupies raw[10i+9:10i]: low guard, 8 data bits, high (carry) guard.
    for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
        assign w_data[8*g +: 8] = in_raw[10*g+1 +: 8];
        assign w_ghi[g]         = in_raw[10*g+9];
        assign w_glo[g]         = in_raw[10*g];
    end

    assign w_unused = ^{w_glo, in_raw[RAW_WIDTH-1], in_opsel[OPSEL_WIDTH-2:0]};

    // An element's carry lives in the high guard bit of its most-significant byte.
    always_comb begin
        w_carry = '0;
        w_lanes = '0;
        unique case (in_sew)
            2'd0: begin
                w_carry = w_ghi;
                w_lanes = 8'hFF;
            end
            2'd1: begin
                w_carry = {4'b0000, w_ghi[7], w_ghi[5], w_ghi[3], w_ghi[1]};
                w_lanes = 8'h0F;
            end
            2'd2: begin
                w_carry = {6'b000000, w_ghi[7], w_ghi[3]};
                w_lanes = 8'h03;
            end
            default: begin
                w_carry = {7'b0000000, w_ghi[7]};
                w_lanes = 8'h01;
            end
        endcase
    end

    assign w_flags   = in_opsel[OPSEL_WIDTH-1] ? w_carry : (~w_carry & w_lanes);
    assign w_n       = 4'd8 >> in_sew;
    assign w_ptr_sum = r_mask_ptr + {3'b000, w_n};
    assign w_emit    = in_mask_op & ((w_ptr_sum == 7'd64) | in_last);

    assign w_acc_upd = r_mask_acc
                     | ({{(REQ_DATA_WIDTH-NBYTES){1'b0}}, w_flags} << r_mask_ptr[5:0]);
    assign w_keep    = w_ptr_sum[6] ? '1
                                    : ((64'd1 << w_ptr_sum[5:0]) - 64'd1);

    // Non-emitting mask beats only touch the accumulator, so they bypass output backpressure.
    assign w_out_free = ~r_out_valid | out_ready;
    assign in_ready   = w_out_free | (in_mask_op & ~w_emit);
    assign w_accept   = in_valid & in_ready;
    assign w_load     = w_accept & (~in_mask_op | w_emit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_is_mask <= 1'b0;
            r_out_last    <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= in_mask_op ? (w_acc_upd & w_keep) : w_data;
            r_out_is_mask <= in_mask_op;
            r_out_last    <= in_last;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask_ptr <= '0;
            r_mask_acc <= '0;
        end else if (w_accept && in_mask_op) begin
            if (w_emit) begin
                r_mask_ptr <= '0;
                r_mask_acc <= '0;
            end else begin
                r_mask_ptr <= w_ptr_sum;
                r_mask_acc <= w_acc_upd;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_is_mask = r_out_is_mask;
    assign out_last    = r_out_last;

endmodule

// File: tb/tb_vadd_result_pack.sv
// Scoreboard bench for vadd_result_pack: directed scenarios plus randomized instructions,
// with expected words built from chosen bytes/flags and checked by an independent monitor.
module tb_vadd_result_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [80:0] in_raw;
    logic [1:0]  in_sew;
    logic [4:0]  in_opsel;
    logic        in_mask_op;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_is_mask;
    logic        out_last;

    vadd_result_pack #(
        .REQ_DATA_WIDTH(64),
        .RAW_WIDTH(81),
        .SEW_WIDTH(2),
        .OPSEL_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_raw(in_raw),
        .in_sew(in_sew), .in_opsel(in_opsel), .in_mask_op(in_mask_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_mask(out_is_mask), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        is_mask;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_mode = 2;   // 0 random, 1 held low, 2 held high
    logic [63:0] m_acc = '0;
    int          m_ptr = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: flags are appended to a growing 64-bit mask word, bit position = element order.
    task automatic model_accept(input logic [63:0] d, input logic [7:0] f, input logic [1:0] sew,
                                input logic mop, input logic last);
        word_t w;
        int n;
        if (!mop) begin
            w.data = d; w.is_mask = 1'b0; w.last = last;
            exp_q.push_back(w);
        end else begin
            n = 8 >> sew;
            for (int k = 0; k < n; k++) m_acc[m_ptr + k] = f[k];
            m_ptr += n;
            if (m_ptr == 64 || last) begin
                w.data = m_acc; w.is_mask = 1'b1; w.last = last;
                exp_q.push_back(w);
                m_acc = '0;
                m_ptr = 0;
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge on which the beat was taken.
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] f, input logic [1:0] sew,
                              input logic [4:0] opsel, input logic mop, input logic last,
                              output int stalls);
        logic [7:0] glo, ghi;
        logic [80:0] raw;
        int es;
        glo = 8'($urandom);
        ghi = 8'($urandom);
        es  = 1 << sew;
        if (mop)
            for (int k = 0; k < (8 >> sew); k++)
                ghi[k*es + es - 1] = opsel[4] ? f[k] : ~f[k];
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[10*i]        = glo[i];
            raw[10*i+1 +: 8] = d[8*i +: 8];
            raw[10*i+9]      = ghi[i];
        end
        raw[80] = 1'($urandom);
        in_raw = raw; in_sew = sew; in_opsel = opsel; in_mask_op = mop; in_last = last;
        in_valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, f, sew, mop, last);
                @(posedge clk); #1;
                break;
            end
            stalls++;
            if (stalls > 300) begin
                chk("in_ready_timeout", 66'(stalls), 66'd0);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_queue_empty", 66'(exp_q.size()), 66'd0);
    endtask

    always begin
        @(posedge clk); #2;
        if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else                 out_ready = (ready_mode == 2);
    end

    // Monitor: pops on every transfer and checks that a stalled word holds still.
    initial begin
        word_t held, w;
        logic  stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stalled = 1'b0;
            end else if (out_valid) begin
                if (stalled)
                    chk("stall_hold", {out_data, out_is_mask, out_last}, held);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", {out_data, out_is_mask, out_last}, 66'd0);
                        n_bad += (out_data == 0 && !out_is_mask && !out_last) ? 1 : 0;
                    end else begin
                        w = exp_q.pop_front();
                        chk("output_word", {out_data, out_is_mask, out_last}, w);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {out_data, out_is_mask, out_last};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        int st, tot, nb, n;
        logic [1:0] sew;
        logic [4:0] op;
        logic mop;
        rst = 1'b0; in_valid = 1'b0; in_raw = '0; in_sew = '0; in_opsel = '0;
        in_mask_op = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_out_valid", 66'(out_valid), 66'd0);
        chk("reset_out_data", 66'(out_data), 66'd0);
        chk("reset_out_is_mask", 66'(out_is_mask), 66'd0);
        chk("reset_out_last", 66'(out_last), 66'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // SEW=8 data: every byte 0x01+0x02
        drive_beat(64'h0303030303030303, 8'h00, 2'd0, 5'h00, 1'b0, 1'b1, st);
        wait_drain();

        // SEW=8 vmadc, 8 all-carry beats -> one full mask word
        for (int b = 0; b < 8; b++)
            drive_beat(64'h0000000000000000, 8'hFF, 2'd0, 5'h10, 1'b1, b == 7, st);
        wait_drain();

        // SEW=64 vmadc, carries 1,0,1 -> 0x5 (borrow polarity on the middle one)
        drive_beat(64'hFFFFFFFFFFFFFFFF, 8'h01, 2'd3, 5'h10, 1'b1, 1'b0, st);
        drive_beat(64'h0123456789ABCDEF, 8'h00, 2'd3, 5'h00, 1'b1, 1'b0, st);
        drive_beat(64'h0, 8'h01, 2'd3, 5'h03, 1'b1, 1'b1, st);
        wait_drain();

        // Backpressure: output held for 5 cycles, next data beat must wait
        ready_mode = 1;
        @(posedge clk); #1;
        drive_beat(64'hA5A5_0F0F_1234_5678, 8'h00, 2'd2, 5'h01, 1'b0, 1'b0, st);
        fork
            drive_beat(64'h5A5A_F0F0_8765_4321, 8'h00, 2'd2, 5'h01, 1'b0, 1'b1, st);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 66'(in_ready), 66'd0);
                    chk("stall_out_valid", 66'(out_valid), 66'd1);
                end
                ready_mode = 2;
            end
        join
        wait_drain();

        // Async reset with 24 mask bits pending and a stale output word
        drive_beat(64'hDEAD_BEEF_CAFE_F00D, 8'h00, 2'd0, 5'h00, 1'b0, 1'b0, st);
        ready_mode = 1;
        for (int b = 0; b < 3; b++)
            drive_beat(64'h0, 8'($urandom) | 8'h01, 2'd0, 5'h10, 1'b1, 1'b0, st);
        #3;
        rst = 1'b0;
        #1;
        chk("midreset_out_valid", 66'(out_valid), 66'd0);
        chk("midreset_out_data", 66'(out_data), 66'd0);
        chk("midreset_out_is_mask", 66'(out_is_mask), 66'd0);
        chk("midreset_out_last", 66'(out_last), 66'd0);
        exp_q.delete();
        m_acc = '0;
        m_ptr = 0;
        ready_mode = 2;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        drive_beat(64'h0, 8'h01, 2'd3, 5'h10, 1'b1, 1'b1, st);
        wait_drain();

        // Back-to-back data with a free consumer: never a stall
        tot = 0;
        for (int b = 0; b < 16; b++) begin
            drive_beat({$urandom, $urandom}, 8'h00, 2'(b), 5'(b), 1'b0, b == 15, st);
            tot += st;
        end
        chk("full_throughput_stalls", 66'(tot), 66'd0);
        wait_drain();

        // Random instructions under random backpressure
        ready_mode = 0;
        for (int ins = 0; ins < 60; ins++) begin
            sew = 2'($urandom);
            op  = 5'($urandom);
            mop = 1'($urandom);
            n   = 8 >> sew;
            nb  = mop ? $urandom_range(1, 64 / n + 3) : $urandom_range(1, 4);
            for (int b = 0; b < nb; b++)
                drive_beat({$urandom, $urandom}, 8'($urandom), sew, op, mop, b == nb - 1, st);
        end
        ready_mode = 2;
        wait_drain();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
